// File: rtl/q_link_pkg.sv
// Shared definitions for the q_serialized pulse link (serializer and measurement ends).
// Provides the FSM state encoding, default link constants and the timer-width helper.
// No logic of its own; no latency or backpressure.
package q_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      HIGH,
      LOW,
      DONE
   } q_state_t;

   localparam int Q_PER_PULSE_DEF    = 30;
   localparam int PULSE_DURATION_DEF = 3;
   localparam int GAP_DURATION_DEF   = 2;

   // The timer holds duration-1, so $clog2(max) bits suffice; keep at least one bit.
   function automatic int timer_width(input int pulse_dur, input int gap_dur);
      int longest;
      longest = (pulse_dur > gap_dur) ? pulse_dur : gap_dur;
      return (longest <= 1) ? 1 : $clog2(longest);
   endfunction

endpackage

// File: rtl/q_serializer_duration_timer.sv
// Loadable down-counter that times the HIGH and LOW phases of each pulse.
// expired is high while the count is zero; a load takes effect on the next edge.
// No backpressure: load always wins over counting.
module duration_timer
   import q_link_pkg::*;
#(
   parameter int WIDTH = timer_width(PULSE_DURATION_DEF, GAP_DURATION_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/q_serializer.sv
// Converts one charge value per start into a train of fixed-width pulses on q_serialized.
// Latency: done arrives 2 + N*(PULSE_DURATION+GAP_DURATION+1) cycles after the start edge.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module q_serializer
   import q_link_pkg::*;
#(
   parameter int BUS_WIDTH      = 10,
   parameter int Q_PER_PULSE    = Q_PER_PULSE_DEF,
   parameter int PULSE_DURATION = PULSE_DURATION_DEF,
   parameter int GAP_DURATION   = GAP_DURATION_DEF,
   parameter bit CARRY_RESIDUE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BUS_WIDTH-1:0] q_in,
   output logic                 q_serialized,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] pulses_sent
);

   localparam int TW = timer_width(PULSE_DURATION, GAP_DURATION);
   localparam logic [BUS_WIDTH:0] Q_STEP    = (BUS_WIDTH + 1)'(Q_PER_PULSE);
   localparam logic [TW-1:0]      HIGH_LOAD = TW'(PULSE_DURATION - 1);
   localparam logic [TW-1:0]      LOW_LOAD  = TW'(GAP_DURATION - 1);

   q_state_t             state;
   q_state_t             next_state;
   logic [BUS_WIDTH:0]   acc;
   logic [BUS_WIDTH-1:0] residue;
   logic [BUS_WIDTH-1:0] cnt;
   logic                 pulse_due;
   logic                 tmr_load;
   logic [TW-1:0]        tmr_val;
   logic                 tmr_expired;

   assign pulse_due = (acc >= Q_STEP);

   // q_serialized is registered alongside the state so it can never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         q_serialized <= 1'b0;
      end else begin
         state        <= next_state;
         q_serialized <= (next_state == HIGH);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CHECK;
         CHECK:   next_state = pulse_due ? HIGH : DONE;
         HIGH:    if (tmr_expired) next_state = LOW;
         LOW:     if (tmr_expired) next_state = CHECK;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      tmr_load = 1'b0;
      tmr_val  = HIGH_LOAD;
      case (state)
         CHECK:   tmr_load = pulse_due;
         HIGH: begin
            tmr_load = tmr_expired;
            tmr_val  = LOW_LOAD;
         end
         default: ;
      endcase
   end

   // Division by repeated subtraction: each CHECK with enough charge emits one pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         residue     <= '0;
         pulses_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= (BUS_WIDTH + 1)'(q_in)
                       + (CARRY_RESIDUE ? (BUS_WIDTH + 1)'(residue) : '0);
                  cnt <= '0;
               end
            end
            CHECK: begin
               if (pulse_due) begin
                  acc <= acc - Q_STEP;
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               pulses_sent <= cnt;
               residue     <= acc[BUS_WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   duration_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .expired (tmr_expired)
   );

endmodule

// File: tb/tb_q_serializer.sv
// Bench for q_serializer: frame table with scoreboard, pulse-shape monitor,
// start-while-busy, reset mid-frame and a residue-discarding instance.
module tb_q_serializer;

   localparam int BW  = 10;
   localparam int QPP = 30;
   localparam int PD  = 3;
   localparam int GD  = 2;
   localparam int PER = PD + GD + 1;

   typedef struct {
      logic [BW-1:0] q;
      int            n;
      int            res;
   } vec_t;

   typedef struct {
      int n;
      int res;
      int lat;
      int k;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [BW-1:0] q_in = '0;
   logic          q_ser;
   logic          busy;
   logic          done;
   logic [BW-1:0] pulses_sent;

   logic          start_nc = 1'b0;
   logic [BW-1:0] q_in_nc = '0;
   logic          q_ser_nc;
   logic          busy_nc;
   logic          done_nc;
   logic [BW-1:0] pulses_sent_nc;

   int  n_vec = 0;
   int  n_err = 0;
   int  cyc = 0;
   sb_t sb[$];
   vec_t vecs[10];

   q_serializer #(
      .BUS_WIDTH(BW), .Q_PER_PULSE(QPP), .PULSE_DURATION(PD),
      .GAP_DURATION(GD), .CARRY_RESIDUE(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .q_in(q_in),
      .q_serialized(q_ser), .busy(busy), .done(done), .pulses_sent(pulses_sent)
   );

   q_serializer #(
      .BUS_WIDTH(BW), .Q_PER_PULSE(QPP), .PULSE_DURATION(PD),
      .GAP_DURATION(GD), .CARRY_RESIDUE(1'b0)
   ) dut_nc (
      .clk(clk), .rst(rst), .start(start_nc), .q_in(q_in_nc),
      .q_serialized(q_ser_nc), .busy(busy_nc), .done(done_nc), .pulses_sent(pulses_sent_nc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pulse-shape monitor and scoreboard consumer for the carrying instance.
   logic prev = 1'b0;
   int   hi_run = 0;
   int   lo_run = 0;
   int   rises = 0;
   int   rises_saved = 0;
   bit   pend = 1'b0;
   sb_t  cur;

   always @(negedge clk) begin
      if (rst) begin
         hi_run = 0;
         lo_run = 0;
         rises  = 0;
         pend   = 1'b0;
         prev   = 1'b0;
      end else begin
         if (pend) begin
            check("pulses_sent", pulses_sent, cur.n);
            check("residue", dut.residue, cur.res);
            check("loopback_q_measured", rises_saved * QPP, pulses_sent * QPP);
            pend = 1'b0;
         end
         if (sb.size() > 0) begin
            if (q_ser && !prev) begin
               if (rises == 0) check("first_rise_lat", cyc - sb[0].k + 1, 2);
               else            check("gap_len", lo_run, GD + 1);
               rises++;
               hi_run = 0;
            end
            if (!q_ser && prev) begin
               check("pulse_width", hi_run, PD);
               lo_run = 0;
            end
            if (q_ser) hi_run++;
            else       lo_run++;
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               cur = sb.pop_front();
               check("done_lat", cyc - cur.k + 1, cur.lat);
               check("pulse_count", rises, cur.n);
               rises_saved = rises;
               rises = 0;
               pend = 1'b1;
            end
         end
         prev = q_ser;
      end
   end

   task automatic wait_sb_empty();
      int w;
      w = 0;
      while (sb.size() > 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() > 0) begin
         check("frame_timeout", 0, 1);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [BW-1:0] q, input int n, input int res);
      @(negedge clk);
      start = 1'b1;
      q_in  = q;
      @(posedge clk);
      #1;
      sb.push_back('{n: n, res: res, lat: 2 + n * PER, k: cyc});
      start = 1'b0;
      q_in  = BW'($urandom);
      wait_sb_empty();
   endtask

   task automatic run_nc(input logic [BW-1:0] q, input int n);
      int k;
      int w;
      int r;
      logic p;
      @(negedge clk);
      start_nc = 1'b1;
      q_in_nc  = q;
      @(posedge clk);
      #1;
      k = cyc;
      start_nc = 1'b0;
      w = 0;
      r = 0;
      p = 1'b0;
      while (!done_nc && w < 400) begin
         @(negedge clk);
         if (q_ser_nc && !p) r++;
         p = q_ser_nc;
         w++;
      end
      check("nc_done_seen", done_nc, 1);
      check("nc_done_lat", cyc - k + 1, 2 + n * PER);
      check("nc_pulse_count", r, n);
      @(negedge clk);
      check("nc_pulses_sent", pulses_sent_nc, n);
   endtask

   initial begin
      int k;
      int w;

      // Running residue with carry: each row's acc = q + previous residue.
      vecs[0] = '{q: 10'd95,   n: 3,  res: 5};
      vecs[1] = '{q: 10'd25,   n: 1,  res: 0};
      vecs[2] = '{q: 10'd1023, n: 34, res: 3};
      vecs[3] = '{q: 10'd26,   n: 0,  res: 29};
      vecs[4] = '{q: 10'd1023, n: 35, res: 2};
      vecs[5] = '{q: 10'd0,    n: 0,  res: 2};
      vecs[6] = '{q: 10'd28,   n: 1,  res: 0};
      vecs[7] = '{q: 10'd59,   n: 1,  res: 29};
      vecs[8] = '{q: 10'd600,  n: 20, res: 29};
      vecs[9] = '{q: 10'd30,   n: 1,  res: 29};

      #2;
      check("rst_q_serialized", q_ser, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pulses_sent", pulses_sent, 0);
      check("rst_residue", dut.residue, 0);
      check("rst_acc", dut.acc, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_frame(vecs[i].q, vecs[i].n, vecs[i].res);

      // start held through a frame while q_in toggles: one frame on 95+29=124.
      @(negedge clk);
      start = 1'b1;
      q_in  = 10'd95;
      @(posedge clk);
      #1;
      sb.push_back('{n: 4, res: 4, lat: 2 + 4 * PER, k: cyc});
      w = 0;
      while (!done && w < 400) begin
         @(negedge clk);
         if (!done) q_in = BW'($urandom);
         w++;
      end
      check("held_done_seen", done, 1);
      q_in = 10'd30;
      @(posedge clk);
      #1;
      check("held_idle_after_done", busy, 0);
      @(posedge clk);
      #1;
      check("held_accept_earliest", busy, 1);
      sb.push_back('{n: 1, res: 4, lat: 2 + 1 * PER, k: cyc});
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sb_empty();
      repeat (4) @(negedge clk);
      check("start_not_queued", busy, 0);

      // Reset during the second HIGH cycle of pulse 2 of a 99-charge frame.
      @(negedge clk);
      start = 1'b1;
      q_in  = 10'd95;
      @(posedge clk);
      #1;
      k = cyc;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      check("rst_point_cycle", cyc - k, 14);
      check("pre_reset_high", q_ser, 1);
      rst = 1'b1;
      #1;
      check("async_drop", q_ser, 0);
      check("async_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_pulses_sent", pulses_sent, 0);
      check("post_rst_residue", dut.residue, 0);
      run_frame(10'd95, 3, 5);

      // Residue discarded: 25 alone is below one pulse.
      run_nc(10'd95, 3);
      run_nc(10'd25, 0);
      run_nc(10'd59, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/q_serializer.md
# q_serializer

Emits the serialized charge pulse stream that `q_measurement` consumes. Each start command converts one charge value into a train of fixed-width pulses on `q_serialized`, with one pulse per `Q_PER_PULSE` units of charge. The block is the transmitting end of the `q_serialized` link. It drives resonant-system emulation benches and loopback tests of the measurement/bisection loop. The sub-`Q_PER_PULSE` residue is optionally carried into the next frame, so charge is conserved across frames.

## Interface
Parameters:
- `BUS_WIDTH`, 10, width of charge input and pulse count.
- `Q_PER_PULSE`, 30, charge units represented by one pulse; must be ≥1 and < 2^BUS_WIDTH.
- `PULSE_DURATION`, 3, cycles `q_serialized` stays high per pulse; must be ≥1.
- `GAP_DURATION`, 2, low cycles after each pulse; must be ≥1.
- `CARRY_RESIDUE`, 1, 1 = add previous frame's residue to the next frame's charge; 0 = discard it.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a frame; sampled only in IDLE.
- `q_in`  in  BUS_WIDTH  charge to serialize; latched on the accepted start edge.
- `q_serialized`  out  1  registered pulse stream.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle strobe in the DONE state.
- `pulses_sent`  out  BUS_WIDTH  pulses emitted in the last completed frame; stable until the next DONE.

## Operation
- Registers:
  - `acc` is BUS_WIDTH+1 bits wide. It holds `q_in` plus a residue that is < `Q_PER_PULSE`, so it never overflows.
  - `residue` is BUS_WIDTH bits wide.
  - `timer` covers max(`PULSE_DURATION`, `GAP_DURATION`).
  - `cnt` is BUS_WIDTH bits wide.
- IDLE: on `start`=1, load `acc` = `q_in` + (`CARRY_RESIDUE` ? `residue` : 0), clear `cnt`, then go to CHECK. `start`=0 keeps the state in IDLE.
- CHECK:
  - If `acc` ≥ `Q_PER_PULSE`: subtract `Q_PER_PULSE` from `acc`, increment `cnt`, load `timer`, go to HIGH.
  - Otherwise go to DONE.
- HIGH: `q_serialized`=1 for exactly `PULSE_DURATION` cycles, then go to LOW.
- LOW: `q_serialized`=0 for exactly `GAP_DURATION` cycles, then go to CHECK.
- DONE: `done`=1, `pulses_sent` ← `cnt`, `residue` ← `acc`[BUS_WIDTH-1:0], then go to IDLE.
- The block divides by repeated subtraction. No divider is instantiated.
- `start` while `busy`=1 is ignored and is not queued.
- `q_in` changes after acceptance do not affect the frame in progress.
- Reset values: state IDLE; `q_serialized`, `busy` and `done` all 0; `pulses_sent`, `residue`, `acc`, `cnt` and `timer` all 0.
- Reset mid-frame:
  - `q_serialized` drops to 0 asynchronously.
  - The partial frame is lost, with no `done` and no update to `pulses_sent`.
  - `residue` is cleared.

## Timing
- Let k be the edge that samples an accepted `start`.
- CHECK occupies cycle k+1. Pulse i (i = 0…N-1) is high in cycles k+2+i·P through k+1+i·P+`PULSE_DURATION`, where P = `PULSE_DURATION`+`GAP_DURATION`+1.
- N = floor(`acc`/`Q_PER_PULSE`). `done` is high in cycle k+2+N·P. `busy` is high from k+1 through the `done` cycle.
- The earliest next accepted `start` is sampled in cycle k+3+N·P.
- With N=0, `done` arrives at k+2 and `q_serialized` never rises.
- `q_serialized` is glitch-free because it is decoded from a registered state.
- Consecutive pulses are separated by `GAP_DURATION`+1 low cycles, made up of the LOW cycles plus the CHECK cycle.

## Structure
- Shared package `q_link_pkg`:
  - state enum {IDLE, CHECK, HIGH, LOW, DONE};
  - a localparam function for the timer width ($clog2 of the max duration);
  - default link constants (`Q_PER_PULSE`, `PULSE_DURATION`), shared with `q_measurement`.
- One sub-module, `duration_timer`: a loadable down-counter with a `load` input, a load value, and an `expired` output. It is used for both the HIGH and LOW phases.

## Test plan
- Default parameters with residue 0. Start with `q_in`=95 → 3 pulses, each 3 cycles high. First rise at k+2, `done` at k+20, `pulses_sent`=3, `residue`=5.
- Follow-up start with `q_in`=25 and `CARRY_RESIDUE`=1 → `acc`=30, 1 pulse, `pulses_sent`=1, `residue`=0. The same stimulus with `CARRY_RESIDUE`=0 gives 0 pulses and `done` at k+2.
- `q_in`=1023, which is all ones → 34 pulses, `residue`=3, `done` at k+2+34·6 = k+206. With a prior `residue`=29, `acc`=1052 without overflow → 35 pulses, `residue`=2.
- `start` held high throughout a frame with `q_in` toggling → exactly one frame runs on the first-sampled value. A second frame begins only when `start` is sampled in IDLE.
- Assert `rst` during the second HIGH cycle of pulse 2 → `q_serialized`=0 immediately, with no `done`. After release, `pulses_sent` and `residue` read 0 and the next frame starts clean.
- Loopback into `q_measurement` with matching parameters, using `q_in` ∈ {0, 30, 59, 600} → `q_measured` equals `pulses_sent`·`Q_PER_PULSE` for each frame.
